// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Contents: FSM state enum, op encodings, default operand width and the
// iteration-counter width helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int unsigned DEF_WIDTH = 32;

  // The counter is loaded with WIDTH and counts down to 1, so it must hold WIDTH itself.
  function automatic int unsigned iter_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/muldiv_unit_booth_step.sv
// One radix-2 Booth iteration: add/subtract/skip on {q0, q-1}, then an
// arithmetic right shift of {acc, q, q-1}.
// Ports:
//   acc, m, q, q_1       : current accumulator, multiplicand, multiplier, q-1
//   acc_next, q_next,
//   q_1_next             : register contents after the step
module booth_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  // One guard bit so acc +/- m (e.g. with m = most-negative) cannot lose its sign.
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {acc[WIDTH-1], acc};
    case ({q[0], q_1})
      2'b01:   sum = {acc[WIDTH-1], acc} + {m[WIDTH-1], m};
      2'b10:   sum = {acc[WIDTH-1], acc} - {m[WIDTH-1], m};
      default: sum = {acc[WIDTH-1], acc};
    endcase
    acc_next = sum[WIDTH:1];
    q_next   = {sum[0], q[WIDTH-1:1]};
    q_1_next = q[0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Sequential signed multiply/divide unit producing a 2*WIDTH result as
// zhi/zlo halves for the bus multiplexer.
// Configuration: define MULDIV_DIV_EN to include the restoring divider;
// without it a DIV request completes immediately with zero results and
// div_by_zero set.
// Ports:
//   clock, clear      : clock, asynchronous active-high reset
//   start, op, a, b   : request, 0=MUL/1=DIV, two's-complement operands
//   busy, done        : busy during iterations, one-cycle completion pulse
//   zhi, zlo          : MUL high/low word, DIV remainder/quotient
//   div_by_zero       : set by the last op if it divided by zero
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zhi,
  output logic [WIDTH-1:0] zlo,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = iter_cnt_w(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;   // Booth acc / division remainder
  logic [WIDTH-1:0]   q_q, q_d;       // Booth multiplier / division quotient
  logic               q1_q, q1_d;
  logic [WIDTH-1:0]   m_q, m_d;       // multiplicand / divisor magnitude
  logic               op_q, op_d;
  logic               busy_d, done_d, dbz_d;
  logic [WIDTH-1:0]   zhi_d, zlo_d;

  logic [WIDTH-1:0]   bs_acc, bs_q;
  logic               bs_q1;

`ifdef MULDIV_DIV_EN
  logic               negq_q, negq_d; // quotient sign differs from magnitude result
  logic               negr_q, negr_d; // remainder takes the dividend's sign
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     trial;

  // Magnitudes fit WIDTH bits unsigned, including the most-negative value.
  assign a_mag = a[WIDTH-1] ? (-a) : a;
  assign b_mag = b[WIDTH-1] ? (-b) : b;
  // Shift remainder left taking the next dividend bit, then trial-subtract.
  assign trial = {acc_q, q_q[WIDTH-1]} - {1'b0, m_q};
`endif

  booth_step #(.WIDTH(WIDTH)) u_booth (
    .acc      (acc_q),
    .m        (m_q),
    .q        (q_q),
    .q_1      (q1_q),
    .acc_next (bs_acc),
    .q_next   (bs_q),
    .q_1_next (bs_q1)
  );

  // Next-state, datapath and output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    op_d    = op_q;
    zhi_d   = zhi;
    zlo_d   = zlo;
    dbz_d   = div_by_zero;
`ifdef MULDIV_DIV_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif

    case (state_q)
      // The DONE cycle accepts a new request just like IDLE.
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_d  = op;
          cnt_d = CNT_W'(WIDTH);
          acc_d = '0;
          q1_d  = 1'b0;
          dbz_d = 1'b0;
          if (op == OP_MUL) begin
            m_d     = a;
            q_d     = b;
            state_d = CALC;
          end else begin
`ifdef MULDIV_DIV_EN
            m_d    = b_mag;
            q_d    = a_mag;
            negq_d = a[WIDTH-1] ^ b[WIDTH-1];
            negr_d = a[WIDTH-1];
            if (b == '0) begin
              // Raw dividend is parked in q for the zhi result.
              dbz_d   = 1'b1;
              q_d     = a;
              state_d = FIX;
            end else begin
              state_d = CALC;
            end
`else
            state_d = FIX;
`endif
          end
        end
      end

      CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q == OP_MUL) begin
          acc_d = bs_acc;
          q_d   = bs_q;
          q1_d  = bs_q1;
        end else begin
`ifdef MULDIV_DIV_EN
          if (!trial[WIDTH]) begin
            acc_d = trial[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
            q_d   = {q_q[WIDTH-2:0], 1'b0};
          end
`endif
        end
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end

      FIX: begin
        state_d = DONE;
        if (op_q == OP_MUL) begin
          zhi_d = acc_q;
          zlo_d = q_q;
        end else begin
`ifdef MULDIV_DIV_EN
          if (div_by_zero) begin
            zhi_d = q_q;
            zlo_d = '1;
          end else begin
            zlo_d = negq_q ? (-q_q) : q_q;
            zhi_d = negr_q ? (-acc_q) : acc_q;
          end
`else
          zhi_d = '0;
          zlo_d = '0;
          dbz_d = 1'b1;
`endif
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      q_q         <= '0;
      q1_q        <= 1'b0;
      m_q         <= '0;
      op_q        <= OP_MUL;
      busy        <= 1'b0;
      done        <= 1'b0;
      zhi         <= '0;
      zlo         <= '0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      q_q         <= q_d;
      q1_q        <= q1_d;
      m_q         <= m_d;
      op_q        <= op_d;
      busy        <= busy_d;
      done        <= done_d;
      zhi         <= zhi_d;
      zlo         <= zlo_d;
      div_by_zero <= dbz_d;
`ifdef MULDIV_DIV_EN
      negq_q      <= negq_d;
      negr_q      <= negr_d;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; expectations follow the
// MULDIV_DIV_EN setting of the build.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] zhi;
  logic [31:0] zlo;
  logic        div_by_zero;

  int n_chk = 0;
  int n_bad = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .zhi         (zhi),
    .zlo         (zlo),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for done. lat = edges after the start edge.
  task automatic run_op(input logic o, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int busy_cnt);
    @(negedge clock);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(negedge clock);
      lat++;
      if (busy) busy_cnt++;
    end
    if (!done) begin
      n_chk++;
      n_bad++;
      $display("FAIL timeout: no done within %0d cycles", lat);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bc, done_cnt;
    clear = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_zhi",  64'(zhi),  64'd0);
    chk("rst_zlo",  64'(zlo),  64'd0);
    chk("rst_dbz",  64'(div_by_zero), 64'd0);
    clear = 1'b0;

    // 7 * -3 = -21
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, bc);
    chk("mul1_lat",  64'(lat), 64'd33);
    chk("mul1_busy", 64'(bc),  64'd32);
    chk("mul1_zhi",  64'(zhi), 64'hFFFF_FFFF);
    chk("mul1_zlo",  64'(zlo), 64'hFFFF_FFEB);
    chk("mul1_dbz",  64'(div_by_zero), 64'd0);
    @(negedge clock);
    chk("mul1_pulse", 64'(done), 64'd0);

    // (-2^31)^2 = 2^62
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, bc);
    chk("mul2_zhi", 64'(zhi), 64'h4000_0000);
    chk("mul2_zlo", 64'(zlo), 64'h0);

`ifdef MULDIV_DIV_EN
    // -7 / 2 -> q=-3, r=-1
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bc);
    chk("div1_lat", 64'(lat), 64'd33);
    chk("div1_zlo", 64'(zlo), 64'hFFFF_FFFD);
    chk("div1_zhi", 64'(zhi), 64'hFFFF_FFFF);
    chk("div1_dbz", 64'(div_by_zero), 64'd0);

    // 100 / -7 -> q=-14, r=2
    run_op(1'b1, 32'd100, 32'hFFFF_FFF9, lat, bc);
    chk("div2_zlo", 64'(zlo), 64'hFFFF_FFF2);
    chk("div2_zhi", 64'(zhi), 64'd2);

    // most-negative / -1 wraps
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    chk("div3_zlo", 64'(zlo), 64'h8000_0000);
    chk("div3_zhi", 64'(zhi), 64'h0);

    // 5 / 0
    run_op(1'b1, 32'd5, 32'd0, lat, bc);
    chk("dbz_lat", 64'(lat), 64'd1);
    chk("dbz_flag", 64'(div_by_zero), 64'd1);
    chk("dbz_zlo", 64'(zlo), 64'hFFFF_FFFF);
    chk("dbz_zhi", 64'(zhi), 64'd5);
`else
    // Divider absent: 10 / 2 completes at once with zero results
    run_op(1'b1, 32'd10, 32'd2, lat, bc);
    chk("nodiv_lat", 64'(lat), 64'd1);
    chk("nodiv_dbz", 64'(div_by_zero), 64'd1);
    chk("nodiv_zlo", 64'(zlo), 64'h0);
    chk("nodiv_zhi", 64'(zhi), 64'h0);
    chk("nodiv_busy", 64'(bc), 64'd0);
`endif

    // Flag clears on the next accepted start
    run_op(1'b0, 32'd2, 32'd3, lat, bc);
    chk("mul3_dbz", 64'(div_by_zero), 64'd0);
    chk("mul3_zlo", 64'(zlo), 64'd6);
    chk("mul3_zhi", 64'(zhi), 64'd0);

    // MUL 3*4 with a second start at cycle 5 that must be ignored
    @(negedge clock);
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    start = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clock);
    start = 1'b0;
    lat = 5;
    while (!done && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    chk("ign_lat", 64'(lat), 64'd33);
    chk("ign_zlo", 64'(zlo), 64'd12);
    chk("ign_zhi", 64'(zhi), 64'd0);

    // New op aborted by clear at cycle 10; previous result holds until then
    @(negedge clock);
    start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd6;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    chk("hold_zlo", 64'(zlo), 64'd12);
    chk("hold_busy", 64'(busy), 64'd1);
    clear = 1'b1;
    #1;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_zhi",  64'(zhi),  64'd0);
    chk("clr_zlo",  64'(zlo),  64'd0);
    @(negedge clock);
    clear = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) done_cnt++;
    end
    chk("clr_nodone", 64'(done_cnt), 64'd0);
    chk("clr_idle_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Sequential signed multiply/divide unit for the datapath. It produces the 64-bit Z result as two 32-bit halves, `zhi` and `zlo`. These halves drive the Zhi and Zlo inputs of the 32:1 bus multiplexer. Operands are latched from the bus-side A/B registers on `start`. The control unit waits on `done` before issuing ZHIout/ZLOout.

## Interface
- `WIDTH`, default 32: operand width. Results are 2×WIDTH, split into hi and lo halves.
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `clear`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: request an operation. Sampled only while `busy`=0.
- `op`, in, 1: 0 = MUL, 1 = DIV.
- `a`, in, WIDTH: multiplicand or dividend, two's complement.
- `b`, in, WIDTH: multiplier or divisor, two's complement.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`.
- `done`, out, 1: single-cycle pulse when results are valid.
- `zhi`, out, WIDTH: MUL high word; DIV remainder.
- `zlo`, out, WIDTH: MUL low word; DIV quotient.
- `div_by_zero`, out, 1: sticky flag for the last op. Cleared on the next accepted `start`.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- **IDLE**
  - `start`=1 latches `a`, `b`, `op`, loads the iteration counter with WIDTH, clears `div_by_zero`, and moves to CALC.
  - DIV with `b`=0 sets `div_by_zero` and moves straight to FIX.
- **CALC, MUL:** radix-2 Booth.
  - State is the {acc, multiplier, q-1} register.
  - Each cycle add, subtract or skip based on {q0, q-1}, then shift right arithmetically.
  - Runs exactly WIDTH cycles.
- **CALC, DIV:** restoring division on operand magnitudes.
  - Each cycle shift the remainder and quotient left, trial-subtract |b|, and keep the result if it is non-negative.
  - Runs WIDTH cycles.
- **FIX:** writes results, then moves to DONE.
  - MUL: {acc, multiplier} goes to {`zhi`, `zlo`}.
  - DIV: the quotient is negated if sign(a)≠sign(b). The remainder is negated if a<0, so it takes the dividend's sign.
  - Divide-by-zero: `zlo`=all ones, `zhi`=a.
- **DONE:** `done`=1 for one cycle, `busy`=0, then back to IDLE.
- `zhi`/`zlo` change only in FIX or on `clear`. They hold until the next op's FIX.
- Overflow cases wrap without a flag:
  - Most-negative ÷ −1 gives quotient 0x80000000, remainder 0.
  - MUL cannot overflow 2×WIDTH.
- `start` while `busy` is ignored; there is no queueing.
- `op` ≠ 0/1 cannot occur because `op` is 1 bit.

## Timing
- Reset values: `busy`=0, `done`=0, `zhi`=0, `zlo`=0, `div_by_zero`=0, state IDLE.
- `start` is sampled at edge E0.
- Normal op:
  - CALC runs on E1..E32; FIX on E33.
  - `done` is high between E33 and E34, so latency is 33 cycles.
  - A new `start` may be accepted on E34. The cycle `done` is high counts as IDLE for acceptance purposes.
- Divide-by-zero: FIX on E1, `done` high between E1 and E2.
- `clear` mid-operation aborts immediately. All outputs return to their reset values and the partial result is discarded.

## Configuration
- `MULDIV_DIV_EN` defined: full unit as described above.
- `MULDIV_DIV_EN` undefined: divider datapath is removed.
  - `op`=1 goes IDLE→FIX directly.
  - FIX writes `zhi`=`zlo`=0 and sets `div_by_zero`=1.
  - `done` is high between E1 and E2.
  - MUL behaviour and timing are unchanged.

## Structure
- Package `muldiv_pkg` holds:
  - the state enum (IDLE/CALC/FIX/DONE);
  - op constants `OP_MUL`=0, `OP_DIV`=1;
  - the iteration count localparam derived from WIDTH.
- One sub-module, `booth_step`: combinational. Takes acc, the multiplicand and {q0, q-1}; returns the next {acc, q} after add/sub and arithmetic shift.
- The divider step stays inline in `muldiv_unit` so it can be wrapped by `MULDIV_DIV_EN`.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3) → `zhi`=0xFFFFFFFF, `zlo`=0xFFFFFFEB. `done` pulses exactly 33 cycles after the `start` edge; `busy` is high for 32 cycles.
- MUL a=0x80000000, b=0x80000000 → `zhi`=0x40000000, `zlo`=0x00000000.
- DIV a=0xFFFFFFF9 (−7), b=2 → `zlo`=0xFFFFFFFD (−3), `zhi`=0xFFFFFFFF (−1), `div_by_zero`=0.
- DIV a=5, b=0 → `div_by_zero`=1, `zlo`=0xFFFFFFFF, `zhi`=5, `done` 1 cycle after `start`. The next MUL 2×3 clears the flag and gives `zlo`=6.
- Two ops with `clear` interleaved:
  - Start MUL 3×4 and pulse `start` again with different operands at cycle 5 → ignored; result `zlo`=12.
  - Start another op and assert `clear` at cycle 10 → `busy`=0, `zhi`=`zlo`=0 immediately, and no `done` pulse.
- With `MULDIV_DIV_EN` undefined: DIV 10/2 → `zhi`=`zlo`=0, `div_by_zero`=1, `done` 1 cycle after `start`. MUL 7×−3 is unchanged from the first scenario.
